// File: rtl/qspi_flash_reader.sv
// Single-word Quad Output Fast Read (0x6B) engine for the external QSPI flash window.
// Optional one-entry last-word cache: define QSPI_LAST_WORD_CACHE_EN.
module qspi_flash_reader #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned ADDR_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    input  logic [3:0]        qspi_io_i,
    output logic [3:0]        qspi_io_o,
    output logic [3:0]        qspi_io_t,
    output logic              qspi_ck_o,
    output logic              qspi_cs_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
    } state_t;

    localparam logic [7:0] CMD_QOFR = 8'h6B;
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    state_t      state_q;
    logic [5:0]  per_q;
    logic [3:0]  div_q;
    logic [31:0] sh_q;
    logic        io0_q;
    logic [3:0]  io_t_q;
    logic        ck_q;
    logic        cs_q;
    logic        ready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic [23:0] baddr;
    logic        hit;
    logic [31:0] cache_word;

    assign baddr = 24'({addr_i, 2'b00});

    // Nibbles arrive byte-ascending, high nibble first; the last byte received is the MSB.
    function automatic logic [31:0] byte_swap(input logic [31:0] b);
        return {b[7:0], b[15:8], b[23:16], b[31:24]};
    endfunction

    // NOTE: every register below uses <= so all of them sample pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            per_q    <= '0;
            div_q    <= '0;
            sh_q     <= '0;
            io0_q    <= 1'b0;
            io_t_q   <= 4'hF;
            ck_q     <= 1'b0;
            cs_q     <= 1'b1;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        ready_q <= 1'b0;
                        if (hit) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= cache_word;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CMD;
                            cs_q    <= 1'b0;
                            ck_q    <= 1'b0;
                            io_t_q  <= 4'b1110;
                            io0_q   <= CMD_QOFR[7];
                            sh_q    <= {CMD_QOFR[6:0], baddr, 1'b0};
                            per_q   <= '0;
                            div_q   <= '0;
                        end
                    end
                end
                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 4'd1;
                    end else begin
                        div_q <= '0;
                        ck_q  <= ~ck_q;
                        // End of a high half closes one SCK period: sample, then shift.
                        if (ck_q) begin
                            per_q <= per_q + 6'd1;
                            io0_q <= (per_q < 6'd31) ? sh_q[31] : 1'b0;
                            if (state_q == S_DATA) sh_q <= {sh_q[27:0], qspi_io_i};
                            else                   sh_q <= {sh_q[30:0], 1'b0};
                            case (per_q)
                                6'd7:  state_q <= S_ADDR;
                                6'd31: begin
                                    state_q <= S_DUMMY;
                                    io_t_q  <= 4'hF;
                                end
                                6'd39: state_q <= S_DATA;
                                6'd47: begin
                                    state_q  <= S_DONE;
                                    cs_q     <= 1'b1;
                                    rvalid_q <= 1'b1;
                                    rdata_q  <= byte_swap({sh_q[27:0], qspi_io_i});
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef QSPI_LAST_WORD_CACHE_EN
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] tag_q;
    logic [31:0]       cword_q;
    logic              cvalid_q;

    assign hit        = cvalid_q && !flush_i && (tag_q == addr_i);
    assign cache_word = cword_q;

    // NOTE: the cache entry is only a few flops, so tag and word are reset along with the valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            tag_q    <= '0;
            cword_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req_i) addr_q <= addr_i;
            if (flush_i) begin
                cvalid_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                cvalid_q <= 1'b1;
                tag_q    <= addr_q;
                cword_q  <= rdata_q;
            end
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign hit          = 1'b0;
    assign cache_word   = '0;
`endif

    assign ready_o   = ready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign qspi_io_o = {3'b000, io0_q};
    assign qspi_io_t = io_t_q;
    assign qspi_ck_o = ck_q;
    assign qspi_cs_o = cs_q;

endmodule
